// File: rtl/airi5c_uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling FSM
// and a small receive FIFO with overrun and framing-error pulses.
module airi5c_uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_e;

  state_e        state_q, state_d;
  logic          rx_meta_q, rx_s_q, rx_prev_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic          frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic          push, pop, empty, full;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = ((wr_ptr_q - rd_ptr_q) == DEPTH_L);
  assign pop   = !empty && ready_i;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d = START;
          timer_d = '0;
        end
      end
      START: begin
        if (timer_q == HALF_END) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = rx_s_q ? IDLE : DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (timer_q == BIT_END) begin
          timer_d   = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (timer_q == BIT_END) begin
          timer_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = 1'b0;
    if (push) begin
      if (!full || pop) begin
        mem_d[wr_ptr_q[AW-1:0]] = shift_q;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rx_meta_q   <= rx_i;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_s_q;
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      mem_q       <= mem_d;
    end
  end

  assign valid_o     = !empty;
  assign data_o      = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign busy_o      = (state_q != IDLE);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_airi5c_uart_rx.sv
// Directed bench for airi5c_uart_rx: frame table plus glitch, overrun,
// full-with-pop and mid-frame reset sequences.
module tb_airi5c_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, overrun_o, busy_o;

  airi5c_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready), .frame_err_o(frame_err_o), .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int fe_cnt = 0, ov_cnt = 0, v_cnt = 0, both_cnt = 0;
  logic [7:0] pop_q[$];

  always @(negedge clk) begin
    if (valid_o && ready) pop_q.push_back(data_o);
    if (valid_o) v_cnt++;
    if (frame_err_o) fe_cnt++;
    if (overrun_o) ov_cnt++;
    if (frame_err_o && overrun_o) both_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_pops;
    logic [7:0] exp_last;
    int         exp_fe;
    int         exp_vcyc;
  } vec_t;

  vec_t vecs[6];
  int   p0, f0, o0, vc0;

  initial begin
    vecs[0] = '{8'h41, 1'b1, 1, 8'h41, 0, 1};
    vecs[1] = '{8'h55, 1'b0, 0, 8'h00, 1, 0};
    vecs[2] = '{8'hA5, 1'b1, 1, 8'hA5, 0, 1};
    vecs[3] = '{8'h00, 1'b1, 1, 8'h00, 0, 1};
    vecs[4] = '{8'hFF, 1'b1, 1, 8'hFF, 0, 1};
    vecs[5] = '{8'h80, 1'b1, 1, 8'h80, 0, 1};

    tick(3);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_fe", frame_err_o, 0);
    check("rst_ov", overrun_o, 0);
    rst_n = 1'b1;
    tick(5);

    ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      p0 = pop_q.size(); f0 = fe_cnt; o0 = ov_cnt; vc0 = v_cnt;
      send_frame(vecs[k].data, vecs[k].stop);
      tick(20);
      check($sformatf("vec%0d_pops", k), pop_q.size() - p0, vecs[k].exp_pops);
      if (vecs[k].exp_pops > 0)
        check($sformatf("vec%0d_data", k), pop_q[pop_q.size()-1], vecs[k].exp_last);
      check($sformatf("vec%0d_fe", k), fe_cnt - f0, vecs[k].exp_fe);
      check($sformatf("vec%0d_ov", k), ov_cnt - o0, 0);
      check($sformatf("vec%0d_vcyc", k), v_cnt - vc0, vecs[k].exp_vcyc);
      check($sformatf("vec%0d_busy", k), busy_o, 0);
    end

    // Short low glitch on the line
    f0 = fe_cnt; o0 = ov_cnt; vc0 = v_cnt;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(2);
    check("glitch_busy_start", busy_o, 1);
    tick(30);
    check("glitch_idle", busy_o, 0);
    check("glitch_valid", v_cnt - vc0, 0);
    check("glitch_fe", fe_cnt - f0, 0);
    check("glitch_ov", ov_cnt - o0, 0);

    // Overrun: five bytes with consumer stalled
    ready = 1'b0;
    p0 = pop_q.size(); f0 = fe_cnt; o0 = ov_cnt;
    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 1'b1);
      tick(20);
    end
    check("ovr_pulse", ov_cnt - o0, 1);
    check("ovr_fe", fe_cnt - f0, 0);
    check("ovr_valid", valid_o, 1);
    check("ovr_head", data_o, 8'h01);
    ready = 1'b1;
    tick(8);
    ready = 1'b0;
    check("ovr_pops", pop_q.size() - p0, 4);
    for (int i = 0; i < 4; i++)
      if (pop_q.size() > p0 + i)
        check($sformatf("ovr_pop%0d", i), pop_q[p0+i], 8'(i + 1));
    check("ovr_empty", valid_o, 0);
    check("ovr_data_empty", data_o, 8'h00);

    // Full FIFO with a pop in the stop-sample cycle of 0x7E
    send_frame(8'h11, 1'b1); tick(20);
    send_frame(8'h22, 1'b1); tick(20);
    send_frame(8'h33, 1'b1); tick(20);
    send_frame(8'h44, 1'b1); tick(20);
    p0 = pop_q.size(); o0 = ov_cnt;
    fork
      send_frame(8'h7E, 1'b1);
      begin
        tick(154);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
      end
    join
    tick(20);
    check("full_ov", ov_cnt - o0, 0);
    check("full_pop_first", pop_q.size() - p0, 1);
    ready = 1'b1;
    tick(8);
    ready = 1'b0;
    check("full_pops", pop_q.size() - p0, 5);
    if (pop_q.size() > 0) check("full_last", pop_q[pop_q.size()-1], 8'h7E);
    check("full_empty", valid_o, 0);

    // Reset mid-frame drops both buffered and in-flight bytes
    f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'h99, 1'b1);
    tick(20);
    check("rst_buffered", valid_o, 1);
    rx = 1'b0;
    tick(CPB * 4 + 8);
    check("rst_busy_pre", busy_o, 1);
    rst_n = 1'b0;
    #1;
    check("rst_busy_async", busy_o, 0);
    rx = 1'b1;
    tick(4);
    check("rst_fifo_valid", valid_o, 0);
    check("rst_fifo_data", data_o, 8'h00);
    rst_n = 1'b1;
    tick(20);
    ready = 1'b1;
    p0 = pop_q.size();
    send_frame(8'h3C, 1'b1);
    tick(20);
    check("rst_pops", pop_q.size() - p0, 1);
    if (pop_q.size() > p0) check("rst_data_3c", pop_q[p0], 8'h3C);
    check("rst_fe_none", fe_cnt - f0, 0);
    check("rst_ov_none", ov_cnt - o0, 0);
    check("pulse_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
